mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch requester (read-only) and its load/store requester (read/write).
- Sits between the core's ibus/dbus masters and the single-ported memory/interconnect.
- Selects a requester, holds the selection stable until the memory grants it, and tracks outstanding transactions in order. Each response is routed back to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2, depth of the in-order owner tracker (1..8); maximum granted-but-unanswered transactions.
- DATA_PRIO, 1, 1: data requester wins simultaneous requests; 0: instruction requester wins.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- i_req  input  1  instruction read request
- i_addr  input  32  instruction address
- i_gnt  output  1  instruction request accepted this cycle
- i_rvalid  output  1  instruction read data valid
- i_rdata  output  32  instruction read data
- d_req  input  1  data request
- d_we  input  1  1 = write
- d_be  input  4  byte enables
- d_addr  input  32  data address
- d_wdata  input  32  write data
- d_gnt  output  1  data request accepted this cycle
- d_rvalid  output  1  data response valid (reads and writes)
- d_rdata  output  32  data read data
- m_req  output  1  memory request
- m_we  output  1  memory write
- m_be  output  4  memory byte enables
- m_addr  output  32  memory address
- m_wdata  output  32  memory write data
- m_gnt  input  1  memory accepted request
- m_rvalid  input  1  memory response valid (one per granted transaction, in order)
- m_rdata  input  32  memory read data
- resp_err  output  1  sticky: m_rvalid seen with empty tracker

Behaviour:
- Reset (async, rst=1): tracker empty, lock cleared, rr pointer = instruction, resp_err=0. All outputs are 0 while reset is asserted.
- Handshake: a transaction transfers on a cycle with m_req&&m_gnt.
  - i_gnt = m_gnt && m_req && sel==I.
  - d_gnt = m_gnt && m_req && sel==D.
  - Requesters hold req and payload until their gnt.
- m_req = (i_req||d_req) && !full. When full, no request is issued, even if m_rvalid pops an entry in the same cycle (no rvalid-to-req combinational path).
- Selection:
  - If the lock register is set, sel = locked owner.
  - Otherwise a single requester wins.
  - Otherwise priority follows DATA_PRIO (or round-robin; see Optional Feature).
- Lock: set when m_req && !m_gnt, storing sel; cleared on m_gnt. The selection never changes while a request is pending ungranted.
- Payload mux:
  - sel==I: m_addr=i_addr, m_we=0, m_be=4'hF, m_wdata=0.
  - sel==D: d_* forwarded.
- Tracker: circular FIFO of owner bits, MAX_OUTSTANDING entries, push on m_req&&m_gnt, pop on m_rvalid. Simultaneous push and pop keeps the count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- Response routing: on m_rvalid with a non-empty tracker, the head owner gets i_rvalid or d_rvalid = 1 in the same cycle (combinational). rdata = m_rdata is forwarded to both rdata outputs; only the rvalid is steered.
- m_rvalid with an empty tracker is dropped and sets resp_err=1, which holds until reset.
- Zero added latency: grant and response are combinational passthroughs. The only state is the lock, the tracker and the rr pointer.
- Reset mid-transaction discards outstanding entries. Later m_rvalids then set resp_err; the memory side must be reset together with the arbiter.

Optional Feature:
- Macro MEM_ARBITER_RR_EN.
- Defined: on simultaneous unlocked requests the winner alternates. A 1-bit rr pointer names the preferred requester and flips to the other requester after every grant to the preferred one. DATA_PRIO is ignored.
- Undefined: fixed priority per DATA_PRIO, and no rr register is synthesized.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, m_gnt=1 the same cycle, m_rvalid next cycle with m_rdata=0xDEADBEEF -> m_addr=0x100, m_we=0, m_be=F; i_gnt=1; i_rvalid=1 with i_rdata=0xDEADBEEF; d_rvalid=0.
- Conflict, DATA_PRIO=1: i_req and d_req both high, d_we=1, d_addr=0x200, d_be=3 -> d_gnt first, m_we=1, m_be=3; i_gnt on the next cycle; responses return D then I.
- Lock: d_req and m_gnt=0 for 3 cycles, then i_req raised in cycle 2 -> m_addr stays at d_addr through all 3 cycles; d_gnt is issued when m_gnt rises.
- Full, MAX_OUTSTANDING=2: two grants with no m_rvalid -> m_req=0 while requests are pending; one m_rvalid -> m_req=1 on the next cycle.
- Spurious response: m_rvalid=1 with an empty tracker -> no rvalid to either requester; resp_err=1 until rst.
- RR (MEM_ARBITER_RR_EN): both requesters held high, m_gnt=1 for 4 cycles -> grants I, D, I, D.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the instruction bus, data bus and shared memory port
// that meet at mem_arbiter.
// Latency: none (wires only).
// Backpressure: carried by the gnt signals (m_gnt -> i_gnt/d_gnt).
// Modports:
//   master - the arbiter's view: it samples the requesters and the memory
//            responses, and drives grants, steered responses and the memory request.
//   slave  - the attached core and memory: they drive requests and responses,
//            and observe grants and the memory request.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport master (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-fetch and load/store
// requesters, and routes each in-order response back to the requester that issued it.
// Latency: zero; grant and response are combinational passthroughs.
// Backpressure: m_gnt low holds (locks) the selection; a full owner tracker blocks m_req.
// Ports: clk, rst (async active-high); bus (mem_arbiter_if.master) carries the
//   i_*/d_* requester buses and the m_* memory port; resp_err is a sticky flag
//   that records a response arriving while nothing is outstanding.
// Optional: define MEM_ARBITER_RR_EN for round-robin arbitration on simultaneous
//   requests. Otherwise fixed priority per DATA_PRIO applies.
module mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,     // 1..8
    parameter bit DATA_PRIO       = 1'b1   // 1: data wins ties, 0: instruction wins
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus,
    output logic          resp_err
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    // Owner encoding throughout: 0 = instruction, 1 = data.
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic                       lock_vld;
    logic                       lock_owner;

    logic sel;
    logic pref;
    logic m_req_int;
    logic full;
    logic empty;
    logic xfer;
    logic pop;
    logic head;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

`ifdef MEM_ARBITER_RR_EN
    // Preferred requester for ties. It hands preference to the other side
    // whenever the preferred side is granted.
    logic rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (xfer && (sel == rr_ptr)) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    assign pref = rr_ptr;
`else
    assign pref = DATA_PRIO;
`endif

    always_comb begin
        sel = pref;
        if (lock_vld) begin
            sel = lock_owner;
        end else if (bus.i_req && !bus.d_req) begin
            sel = 1'b0;
        end else if (bus.d_req && !bus.i_req) begin
            sel = 1'b1;
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = owner_q[rd_ptr];

    // "full" is the registered count, so a same-cycle pop cannot re-open m_req.
    assign m_req_int = (bus.i_req || bus.d_req) && !full && !rst;
    assign xfer      = m_req_int && bus.m_gnt;
    assign pop       = bus.m_rvalid && !empty && !rst;

    assign bus.m_req   = m_req_int;
    assign bus.i_gnt   = xfer && !sel;
    assign bus.d_gnt   = xfer && sel;
    assign bus.m_we    = !rst && sel && bus.d_we;
    assign bus.m_be    = rst ? 4'h0  : (sel ? bus.d_be    : 4'hF);
    assign bus.m_addr  = rst ? 32'h0 : (sel ? bus.d_addr  : bus.i_addr);
    assign bus.m_wdata = rst ? 32'h0 : (sel ? bus.d_wdata : 32'h0);

    // Only the valid is steered. Data fans out to both requesters.
    assign bus.i_rvalid = pop && !head;
    assign bus.d_rvalid = pop && head;
    assign bus.i_rdata  = rst ? 32'h0 : bus.m_rdata;
    assign bus.d_rdata  = rst ? 32'h0 : bus.m_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lock_vld   <= 1'b0;
            lock_owner <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            // Hold the selection while a request sits ungranted.
            if (bus.m_gnt) begin
                lock_vld <= 1'b0;
            end else if (m_req_int) begin
                lock_vld   <= 1'b1;
                lock_owner <= sel;
            end

            if (xfer) begin
                owner_q[wr_ptr] <= sel;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (xfer && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !xfer) begin
                count <= count - 1'b1;
            end

            if (bus.m_rvalid && empty) begin
                resp_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: checks the mem_arbiter handshake, arbitration, lock, tracker and
// response routing using a vector table plus directed multi-cycle sequences.
// Expected response owners are queued at grant time and compared on m_rvalid.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    logic resp_err;
    int   n_tests;
    int   n_fail;
    bit   exp_q[$];

    mem_arbiter_if bus();

    mem_arbiter #(
        .MAX_OUTSTANDING(2),
        .DATA_PRIO(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        i_req;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic        m_gnt;
        logic        e_mreq;
        logic        e_ignt;
        logic        e_dgnt;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic        chk_pay;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.i_req    = 1'b0;
        bus.i_addr   = 32'h0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_be     = 4'h0;
        bus.d_addr   = 32'h0;
        bus.d_wdata  = 32'h0;
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = 32'h0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pops the expected owner and checks the steered valids and the forwarded data.
    task automatic chk_resp(input logic [31:0] data);
        bit o;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: got a response with no expected entry, expected queue non-empty");
            return;
        end
        n_tests--;
        o = exp_q.pop_front();
        check("i_rvalid", 32'(bus.i_rvalid), 32'(!o));
        check("d_rvalid", 32'(bus.d_rvalid), 32'(o));
        check("i_rdata", bus.i_rdata, data);
        check("d_rdata", bus.d_rdata, data);
    endtask

    // Completes the current cycle, then returns n responses with no new requests.
    task automatic drain(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            cyc();
            idle();
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = base + 32'(k);
            #1;
            chk_resp(base + 32'(k));
        end
        cyc();
        idle();
    endtask

    initial begin
        logic first_d;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle();

        //            name        ireq dreq we  be    gnt  mreq ig  dg  we  be    addr         pay
        tbl[0] = '{"idle",      0,   0,   0,  4'h0, 1,   0,   0,  0,  0,  4'h0, 32'h0,       0};
        tbl[1] = '{"i_gnt",     1,   0,   0,  4'h0, 1,   1,   1,  0,  0,  4'hF, 32'h100,     1};
        tbl[2] = '{"i_wait",    1,   0,   0,  4'h0, 0,   1,   0,  0,  0,  4'hF, 32'h100,     1};
        tbl[3] = '{"d_wr_gnt",  0,   1,   1,  4'h3, 1,   1,   0,  1,  1,  4'h3, 32'h200,     1};
        tbl[4] = '{"d_rd_gnt",  0,   1,   0,  4'hF, 1,   1,   0,  1,  0,  4'hF, 32'h200,     1};
`ifdef MEM_ARBITER_RR_EN
        tbl[5] = '{"both_gnt",  1,   1,   1,  4'h3, 1,   1,   1,  0,  0,  4'hF, 32'h100,     1};
        tbl[6] = '{"both_wait", 1,   1,   1,  4'h3, 0,   1,   0,  0,  0,  4'hF, 32'h100,     1};
`else
        tbl[5] = '{"both_gnt",  1,   1,   1,  4'h3, 1,   1,   0,  1,  1,  4'h3, 32'h200,     1};
        tbl[6] = '{"both_wait", 1,   1,   1,  4'h3, 0,   1,   0,  0,  1,  4'h3, 32'h200,     1};
`endif

        // Outputs forced to zero during reset, even with live inputs.
        bus.i_req = 1'b1; bus.i_addr = 32'h1234; bus.d_req = 1'b1; bus.d_we = 1'b1;
        bus.d_be = 4'hF; bus.d_addr = 32'h5678; bus.d_wdata = 32'h9ABC;
        bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
        #1;
        check("rst_m_req",    32'(bus.m_req),    0);
        check("rst_i_gnt",    32'(bus.i_gnt),    0);
        check("rst_d_gnt",    32'(bus.d_gnt),    0);
        check("rst_i_rvalid", 32'(bus.i_rvalid), 0);
        check("rst_d_rvalid", 32'(bus.d_rvalid), 0);
        check("rst_i_rdata",  bus.i_rdata,       0);
        check("rst_m_addr",   bus.m_addr,        0);
        check("rst_m_be",     32'(bus.m_be),     0);
        check("rst_m_wdata",  bus.m_wdata,       0);
        check("rst_resp_err", 32'(resp_err),     0);

        // Table: one combinational cycle from a freshly reset arbiter.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            bus.i_req  = tbl[v].i_req;
            bus.i_addr = 32'h100;
            bus.d_req  = tbl[v].d_req;
            bus.d_we   = tbl[v].d_we;
            bus.d_be   = tbl[v].d_be;
            bus.d_addr = 32'h200;
            bus.m_gnt  = tbl[v].m_gnt;
            #1;
            check({tbl[v].name, "_m_req"}, 32'(bus.m_req), 32'(tbl[v].e_mreq));
            check({tbl[v].name, "_i_gnt"}, 32'(bus.i_gnt), 32'(tbl[v].e_ignt));
            check({tbl[v].name, "_d_gnt"}, 32'(bus.d_gnt), 32'(tbl[v].e_dgnt));
            if (tbl[v].chk_pay) begin
                check({tbl[v].name, "_m_we"},   32'(bus.m_we), 32'(tbl[v].e_we));
                check({tbl[v].name, "_m_be"},   32'(bus.m_be), 32'(tbl[v].e_be));
                check({tbl[v].name, "_m_addr"}, bus.m_addr,    tbl[v].e_addr);
            end
        end

        // Single fetch with a response on the next cycle.
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h100; bus.m_gnt = 1'b1;
        #1;
        check("fetch_m_addr", bus.m_addr, 32'h100);
        check("fetch_m_we", 32'(bus.m_we), 0);
        check("fetch_m_be", 32'(bus.m_be), 32'hF);
        check("fetch_i_gnt", 32'(bus.i_gnt), 1);
        check("fetch_d_gnt", 32'(bus.d_gnt), 0);
        exp_q.push_back(1'b0);
        drain(1, 32'hDEAD_BEEF);

        // Conflict: the winner is granted first, the loser next cycle, and responses follow grant order.
`ifdef MEM_ARBITER_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_be = 4'h3;
        bus.d_wdata = 32'hCAFE_0001; bus.m_gnt = 1'b1;
        #1;
        check("conf1_d_gnt", 32'(bus.d_gnt), 32'(first_d));
        check("conf1_i_gnt", 32'(bus.i_gnt), 32'(!first_d));
        check("conf1_m_we", 32'(bus.m_we), 32'(first_d));
        check("conf1_m_be", 32'(bus.m_be), first_d ? 32'h3 : 32'hF);
        check("conf1_m_wdata", bus.m_wdata, first_d ? 32'hCAFE_0001 : 32'h0);
        exp_q.push_back(first_d);
        cyc();
        if (first_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
        #1;
        check("conf2_i_gnt", 32'(bus.i_gnt), 32'(first_d));
        check("conf2_d_gnt", 32'(bus.d_gnt), 32'(!first_d));
        check("conf2_m_addr", bus.m_addr, first_d ? 32'h100 : 32'h200);
        exp_q.push_back(!first_d);
        drain(2, 32'hA000_0000);

        // Lock held on data while the instruction requester arrives.
        do_reset();
        bus.d_req = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h300;
        #1;
        check("lockA_c1_addr", bus.m_addr, 32'h300);
        check("lockA_c1_d_gnt", 32'(bus.d_gnt), 0);
        cyc();
        bus.i_req = 1'b1; bus.i_addr = 32'h500;
        #1;
        check("lockA_c2_addr", bus.m_addr, 32'h300);
        check("lockA_c2_i_gnt", 32'(bus.i_gnt), 0);
        cyc();
        #1;
        check("lockA_c3_addr", bus.m_addr, 32'h300);
        cyc();
        bus.m_gnt = 1'b1;
        #1;
        check("lockA_d_gnt", 32'(bus.d_gnt), 1);
        check("lockA_i_gnt0", 32'(bus.i_gnt), 0);
        exp_q.push_back(1'b1);
        cyc();
        bus.d_req = 1'b0;
        #1;
        check("lockA_i_gnt", 32'(bus.i_gnt), 1);
        check("lockA_i_addr", bus.m_addr, 32'h500);
        exp_q.push_back(1'b0);
        drain(2, 32'hB000_0000);

        // Lock held on instruction even though data would win a fresh tie.
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h600;
        #1;
        check("lockB_c1_addr", bus.m_addr, 32'h600);
        cyc();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'h1; bus.d_addr = 32'h700;
        #1;
        check("lockB_c2_addr", bus.m_addr, 32'h600);
        check("lockB_c2_we", 32'(bus.m_we), 0);
        cyc();
        bus.m_gnt = 1'b1;
        #1;
        check("lockB_i_gnt", 32'(bus.i_gnt), 1);
        check("lockB_d_gnt0", 32'(bus.d_gnt), 0);
        exp_q.push_back(1'b0);
        cyc();
        bus.i_req = 1'b0;
        #1;
        check("lockB_d_gnt", 32'(bus.d_gnt), 1);
        check("lockB_d_we", 32'(bus.m_we), 1);
        exp_q.push_back(1'b1);
        drain(2, 32'hC000_0000);

        // Full tracker blocks m_req, including on the cycle a response pops it.
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h400; bus.m_gnt = 1'b1;
        #1;
        check("full_g1", 32'(bus.i_gnt), 1);
        exp_q.push_back(1'b0);
        cyc();
        bus.i_addr = 32'h404;
        #1;
        check("full_g2", 32'(bus.i_gnt), 1);
        exp_q.push_back(1'b0);
        cyc();
        bus.i_addr = 32'h408;
        #1;
        check("full_m_req", 32'(bus.m_req), 0);
        check("full_i_gnt", 32'(bus.i_gnt), 0);
        cyc();
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hD000_0001;
        #1;
        check("full_pop_m_req", 32'(bus.m_req), 0);
        chk_resp(32'hD000_0001);
        cyc();
        bus.m_rvalid = 1'b0;
        #1;
        check("full_reopen_m_req", 32'(bus.m_req), 1);
        check("full_reopen_i_gnt", 32'(bus.i_gnt), 1);
        exp_q.push_back(1'b0);
        drain(2, 32'hD000_0002);
        #1;
        check("full_resp_err", 32'(resp_err), 0);

        // Spurious response: dropped, sticky error until reset.
        do_reset();
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1111_2222;
        #1;
        check("spur_i_rvalid", 32'(bus.i_rvalid), 0);
        check("spur_d_rvalid", 32'(bus.d_rvalid), 0);
        check("spur_err_pre", 32'(resp_err), 0);
        cyc();
        bus.m_rvalid = 1'b0;
        #1;
        check("spur_err_set", 32'(resp_err), 1);
        cyc();
        cyc();
        #1;
        check("spur_err_hold", 32'(resp_err), 1);
        rst = 1'b1;
        #1;
        check("spur_err_clr", 32'(resp_err), 0);
        rst = 1'b0;

`ifdef MEM_ARBITER_RR_EN
        // Round robin: both requesters held, grants alternate I, D, I, D.
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h800;
        bus.d_req = 1'b1; bus.d_addr = 32'h900; bus.d_be = 4'hF;
        bus.m_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.m_rvalid = (k > 0);
            bus.m_rdata  = 32'hE000_0000 + 32'(k);
            #1;
            check("rr_i_gnt", 32'(bus.i_gnt), 32'((k % 2) == 0));
            check("rr_d_gnt", 32'(bus.d_gnt), 32'((k % 2) == 1));
            if (k > 0) chk_resp(32'hE000_0000 + 32'(k));
            exp_q.push_back((k % 2) == 1);
            if (k < 3) cyc();
        end
        drain(1, 32'hE000_0010);
`endif

        check("sb_empty_at_end", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
